// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline WB writes and buffered MDU results onto one registered RF write port.
module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  output logic        rf_RegWrite,
  output logic [4:0]  rf_WA,
  output logic [31:0] rf_WD,
  output logic [31:0] busy_mask,
  output logic        wb_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [4:0]       q_wa [DEPTH];
  logic [31:0]      q_wd [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW-1:0]    wr, rd;
  logic [CW-1:0]    count;
  logic [3:0]       age;
  logic             s_we;
  logic [4:0]       s_wa;
  logic [31:0]      s_wd;
  logic             wb_act, push, pop, hwrite, nonempty, head_live;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign nonempty  = count != '0;
  assign head_live = q_live[rd];
  assign wb_act    = wb_we && wb_wa != 5'd0;
  assign mdu_ready = rstn && (count < CW'(DEPTH));
  assign push      = mdu_valid && mdu_ready && mdu_wa != 5'd0;
  // Dead heads drain every cycle; live heads only when WB is idle.
  assign pop       = nonempty && (!head_live || !wb_act);
  assign hwrite    = nonempty && head_live && !wb_act;
  assign wb_stall  = age >= 4'(STARVE_LIMIT);
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q_live[i]) busy_mask[q_wa[i]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_wa[i] <= '0;
        q_wd[i] <= '0;
      end
      q_live      <= '0;
      wr          <= '0;
      rd          <= '0;
      count       <= '0;
      age         <= '0;
      s_we        <= 1'b0;
      s_wa        <= '0;
      s_wd        <= '0;
      rf_RegWrite <= 1'b0;
      rf_WA       <= '0;
      rf_WD       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wb_act && q_wa[i] == wb_wa) q_live[i] <= 1'b0;
      if (pop) begin
        q_live[rd] <= 1'b0;
        rd         <= inc(rd);
      end
      // A result arriving alongside a WB to the same register is already stale.
      if (push) begin
        q_wa[wr]   <= mdu_wa;
        q_wd[wr]   <= mdu_wd;
        q_live[wr] <= !(wb_act && wb_wa == mdu_wa);
        wr         <= inc(wr);
      end
      count <= count + CW'(push) - CW'(pop);
      age   <= (!nonempty || pop) ? 4'd0 : (head_live && age < 4'(STARVE_LIMIT)) ? age + 4'd1 : age;
      s_we  <= wb_act || hwrite;
      if (wb_act) begin
        s_wa <= wb_wa;
        s_wd <= wb_wd;
      end else if (hwrite) begin
        s_wa <= q_wa[rd];
        s_wd <= q_wd[rd];
      end
      rf_RegWrite <= s_we;
      if (s_we) begin
        rf_WA <= s_wa;
        rf_WD <= s_wd;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench; a queue model predicts RF writes, busy mask, stall and ready.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic wb_we = 1'b0, mdu_valid = 1'b0;
  logic [4:0] wb_wa = '0, mdu_wa = '0;
  logic [31:0] wb_wd = '0, mdu_wd = '0;
  logic mdu_ready, rf_RegWrite, wb_stall;
  logic [4:0] rf_WA;
  logic [31:0] rf_WD, busy_mask;
  typedef struct {logic [4:0] wa; logic [31:0] wd; logic live;} ent_t;
  typedef struct {logic [4:0] wa; logic [31:0] wd; int due;} wr_t;
  ent_t mq[$];
  wr_t exq[$];
  int age = 0, e = 0, checks = 0, errors = 0;
  logic [4:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rstn(rstn), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
    .rf_RegWrite(rf_RegWrite), .rf_WA(rf_WA), .rf_WD(rf_WD),
    .busy_mask(busy_mask), .wb_stall(wb_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask
  function automatic logic [31:0] mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].wa] = 1'b1;
    return m;
  endfunction
  task automatic check_outs();
    logic wr;
    wr = exq.size() > 0 && exq[0].due == e;
    chk("rf_we", 32'(rf_RegWrite), 32'(wr));
    if (wr) begin
      last_wa = exq[0].wa;
      last_wd = exq[0].wd;
      void'(exq.pop_front());
    end
    chk("rf_wa", 32'(rf_WA), 32'(last_wa));
    chk("rf_wd", rf_WD, last_wd);
    chk("busy", busy_mask, mask());
    chk("stall", 32'(wb_stall), 32'(age >= LIM));
    chk("ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
  endtask
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mwa, input logic [31:0] mwd);
    logic wact, push, pop, hw;
    @(negedge clk);
    wb_we = we; wb_wa = wa; wb_wd = wd;
    mdu_valid = mv; mdu_wa = mwa; mdu_wd = mwd;
    @(posedge clk);
    e++;
    wact = we && wa != 0;
    push = mv && mq.size() < DEPTH && mwa != 0;
    pop = 1'b0;
    hw = 1'b0;
    if (mq.size() > 0) begin
      if (!mq[0].live) pop = 1'b1;
      else if (!wact) begin pop = 1'b1; hw = 1'b1; end
    end
    if (wact) exq.push_back('{wa, wd, e + 1});
    else if (hw) exq.push_back('{mq[0].wa, mq[0].wd, e + 1});
    if (mq.size() == 0 || pop) age = 0;
    else if (mq[0].live && age < LIM) age++;
    if (pop) void'(mq.pop_front());
    if (wact) foreach (mq[i]) if (mq[i].wa == wa) mq[i].live = 1'b0;
    if (push) mq.push_back('{mwa, mwd, !(wact && mwa == wa)});
    #1 check_outs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    wb_we = 0; mdu_valid = 0;
    rstn = 1'b0;
    #1;
    chk("rst_we", 32'(rf_RegWrite), 0);
    chk("rst_wa", 32'(rf_WA), 0);
    chk("rst_wd", rf_WD, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", 32'(wb_stall), 0);
    chk("rst_ready", 32'(mdu_ready), 0);
    mq.delete();
    exq.delete();
    age = 0;
    last_wa = '0;
    last_wd = '0;
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("ready_after_rst", 32'(mdu_ready), 1);
  endtask
  initial begin
    do_reset();
    // single WB write
    step(1, 5, 32'hAAAA5555, 0, 0, 0);
    idle(3);
    // MDU result drains through the buffer
    step(0, 0, 0, 1, 7, 32'h12345678);
    idle(3);
    // WB to same register squashes the buffered result
    step(0, 0, 0, 1, 9, 32'hDEAD0009);
    step(1, 9, 32'h1, 0, 0, 0);
    idle(3);
    // same-edge enqueue and WB to the same register
    step(1, 12, 32'hC0C0, 1, 12, 32'hBAD);
    idle(3);
    // full buffer, WB hogging the port until stall, then idle once
    step(1, 1, 32'h11, 1, 2, 32'h22);
    step(1, 1, 32'h12, 1, 3, 32'h33);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h13 + i, 1, 4, 32'h44);
    step(1, 1, 32'h20, 1, 4, 32'h44);
    step(0, 0, 0, 1, 4, 32'h44);
    step(0, 0, 0, 1, 4, 32'h44);
    idle(5);
    // zero-address writes are ignored
    step(1, 0, 32'hFFFF, 1, 0, 32'hEEEE);
    idle(3);
    // random traffic with narrow address range for collisions
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    idle(6);
    chk("drain", 32'(exq.size()), 0);
    // reset with two live entries buffered
    step(1, 3, 32'h5, 1, 6, 32'h66);
    step(1, 3, 32'h6, 1, 8, 32'h88);
    do_reset();
    idle(4);
    chk("post_rst_drain", 32'(exq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of entries in the multi-cycle-unit (MDU) result buffer (legal 2..8).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of cycles a buffered head entry waits before the block requests a WB stall (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports wb_we (in, 1), wb_wa (in, 5), wb_wd (in, 32): the pipeline WB-stage write request, which is never back-pressured.
REQ-006 The block SHALL have ports mdu_valid (in, 1), mdu_ready (out, 1), mdu_wa (in, 5), mdu_wd (in, 32): the MDU result valid/ready channel.
REQ-007 The block SHALL have ports rf_RegWrite (out, 1), rf_WA (out, 5), rf_WD (out, 32): the registered single write port into the register file.
REQ-008 The block SHALL have port busy_mask, output, 32 bits: bit i set while a live buffered write to register i is pending.
REQ-009 The block SHALL have port wb_stall, output, 1 bit: a request that the pipeline present no WB write in the next cycle.

Function
REQ-010 MDU handshake SHALL occur on a clock edge with mdu_valid=1 and mdu_ready=1; mdu_ready SHALL equal (count < DEPTH), derived from registered state only, with no same-cycle pass-through when full.
REQ-011 An accepted MDU result with mdu_wa=0 SHALL be discarded and not enqueued.
REQ-012 Buffer SHALL be FIFO-ordered; each entry holds {wa, wd, live}, with live=1 on enqueue unless REQ-014 applies.
REQ-013 When wb_we=1 and wb_wa≠0, every buffered entry with wa==wb_wa SHALL have live cleared at that edge, so that the older MDU result never overwrites the newer WB value.
REQ-014 A result enqueued at the same edge as a WB write to the same nonzero address SHALL be enqueued with live=0, because the MDU result is the older one.
REQ-015 Arbitration per cycle: if wb_we=1 and wb_wa≠0, the WB request SHALL win; otherwise, if the head is live, the head SHALL be popped and written; a dead head SHALL be popped without a write in any cycle, independent of WB.
REQ-016 The winner SHALL appear on rf_RegWrite/rf_WA/rf_WD one cycle after its decision cycle; rf_RegWrite SHALL be 0 in a cycle with no winner, and rf_WA/rf_WD SHALL then hold their last values.
REQ-017 Latency: a WB request at edge N SHALL appear at edge N+1; an MDU result enqueued at edge N SHALL become eligible from cycle N+1, so its earliest RF write is at edge N+2.
REQ-018 WB writes with wb_wa=0 SHALL be ignored entirely: no RF write and no squash.
REQ-019 Simultaneous enqueue and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 Starvation counter age SHALL increment each cycle the head is live and not popped, saturate at STARVE_LIMIT, and clear on pop or when the buffer is empty.
REQ-021 wb_stall SHALL be 1 when age ≥ STARVE_LIMIT and 0 otherwise.
REQ-022 If wb_we=1 arrives while wb_stall=1 (protocol violation), WB SHALL still win and age SHALL stay saturated.
REQ-023 busy_mask SHALL be the OR of one-hot(wa) over all live entries, computed from registered state.

Reset
REQ-024 While rstn=0, the block SHALL asynchronously force: buffer empty, age=0, rf_RegWrite=0, rf_WA=0, rf_WD=0, busy_mask=0, wb_stall=0, mdu_ready=0.
REQ-025 On the first cycle after rstn deasserts, mdu_ready SHALL be 1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries without RF writes.

Verification
REQ-027 Scenario: WB write r5=0xAAAA5555 at edge 1 -> rf_RegWrite=1, rf_WA=5, rf_WD=0xAAAA5555 after edge 2; no other writes occur.
REQ-028 Scenario: MDU r7=0x12345678 accepted at edge 1, no WB activity -> busy_mask[7]=1 after edge 1; RF write of r7 after edge 3 (per REQ-017); busy_mask=0 after edge 3.
REQ-029 Scenario: MDU r9 enqueued, then WB r9=0x1 the next cycle -> only the WB write reaches the RF; the entry drains with no write; busy_mask[9] clears at the WB edge.
REQ-030 Scenario: DEPTH=2, three back-to-back MDU results while WB writes r1 every cycle -> mdu_ready=0 after two accepts; wb_stall rises once age reaches 4; with WB idle for one cycle, the head is written and mdu_ready returns to 1.
REQ-031 Scenario: MDU mdu_wa=0 and WB wb_wa=0 -> no RF write, busy_mask stays 0, count stays 0.
REQ-032 Scenario: rstn pulsed low with two live entries buffered -> all outputs 0 immediately; no RF write after release; mdu_ready=1 on the next cycle.
